counter_capture_fifo: RTL



---
 rtl/counter_capture_fifo.sv | 73 +++++++
 1 files changed

// File: rtl/counter_capture_fifo.sv
// First-word-fall-through FIFO that snapshots an upstream counter value on each capture strobe.
// Tracks occupancy and holds a sticky overflow flag whenever a capture is dropped on a full FIFO.
module counter_capture_fifo #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  counter_in,
    input  logic              capture,
    input  logic              flush,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_pop;
    logic             do_write;
    logic             drop;

    // One extra pointer bit tells full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level = wr_ptr - rd_ptr;

    // Flush overrides both sides; a pop on a full FIFO frees the slot for a same-cycle write.
    assign do_pop   = ~flush & ~empty & out_ready;
    assign do_write = ~flush & capture & (~full | do_pop);
    assign drop     = ~flush & capture & full & ~do_pop;

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // NOTE: storage has no reset; stale entries are never visible because out_data is gated by empty.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= counter_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
